// File: rtl/ps2_seq_pkg.sv
// ps2_seq_pkg: shared definitions for the ASCII -> PS/2 Set 2 keystroke path.
//   - state_t       : keystroke sequencer states
//   - SCAN_BREAK_PFX: break prefix byte (F0)
//   - SCAN_LSHIFT   : Left-Shift make/break code (12)
//   - letter_code() : a..z make-code table
//   - emit_byte()   : byte presented on the scan output in a given state
// Optional feature macro: SHIFTED_CHARS_EN (adds Shift-wrapped sequences).
package ps2_seq_pkg;

  localparam logic [7:0] SCAN_BREAK_PFX = 8'hF0;
  localparam logic [7:0] SCAN_LSHIFT    = 8'h12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MK      = 3'd1,
    BRK_PFX = 3'd2,
    BRK     = 3'd3
`ifdef SHIFTED_CHARS_EN
    ,
    SH_MK   = 3'd4,
    SH_PFX  = 3'd5,
    SH_BRK  = 3'd6
`endif
  } state_t;

  // Make code of a lowercase letter; anything else returns 00.
  function automatic logic [7:0] letter_code(input logic [7:0] ch);
    logic [7:0] c;
    c = 8'h00;
    case (ch)
      8'h61: c = 8'h1C;  8'h62: c = 8'h32;  8'h63: c = 8'h21;  8'h64: c = 8'h23;
      8'h65: c = 8'h24;  8'h66: c = 8'h2B;  8'h67: c = 8'h34;  8'h68: c = 8'h33;
      8'h69: c = 8'h43;  8'h6A: c = 8'h3B;  8'h6B: c = 8'h42;  8'h6C: c = 8'h4B;
      8'h6D: c = 8'h3A;  8'h6E: c = 8'h31;  8'h6F: c = 8'h44;  8'h70: c = 8'h4D;
      8'h71: c = 8'h15;  8'h72: c = 8'h2D;  8'h73: c = 8'h1B;  8'h74: c = 8'h2C;
      8'h75: c = 8'h3C;  8'h76: c = 8'h2A;  8'h77: c = 8'h1D;  8'h78: c = 8'h22;
      8'h79: c = 8'h35;  8'h7A: c = 8'h1A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Byte driven on the scan output while sitting in state st.
  function automatic logic [7:0] emit_byte(input state_t st, input logic [7:0] code);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      MK, BRK:  b = code;
      BRK_PFX:  b = SCAN_BREAK_PFX;
`ifdef SHIFTED_CHARS_EN
      SH_PFX:   b = SCAN_BREAK_PFX;
      SH_MK,
      SH_BRK:   b = SCAN_LSHIFT;
`endif
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ascii_to_key.sv
// ascii_to_key: purely combinational ASCII -> PS/2 Set 2 key lookup (US layout).
//   ascii [7:0] in  : character
//   code  [7:0] out : make code of the key
//   shift       out : key needs Left-Shift held
//   hit         out : character has a mapping
// With SHIFTED_CHARS_EN undefined, A-Z return their plain key (shift=0) and
// all shifted symbols return hit=0.
module ascii_to_key
  import ps2_seq_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] code,
  output logic       shift,
  output logic       hit
);

  always_comb begin
    code  = 8'h00;
    shift = 1'b0;
    hit   = 1'b0;
    if (ascii >= 8'h61 && ascii <= 8'h7A) begin
      code = letter_code(ascii);
      hit  = 1'b1;
    end else if (ascii >= 8'h41 && ascii <= 8'h5A) begin
      code = letter_code(ascii | 8'h20);
      hit  = 1'b1;
`ifdef SHIFTED_CHARS_EN
      shift = 1'b1;
`endif
    end else begin
      hit = 1'b1;
      case (ascii)
        // digits
        8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1E;
        8'h33: code = 8'h26;  8'h34: code = 8'h25;  8'h35: code = 8'h2E;
        8'h36: code = 8'h36;  8'h37: code = 8'h3D;  8'h38: code = 8'h3E;
        8'h39: code = 8'h46;
        // unshifted punctuation and control keys
        8'h60: code = 8'h0E;  8'h2D: code = 8'h4E;  8'h3D: code = 8'h55;
        8'h5B: code = 8'h54;  8'h5D: code = 8'h5B;  8'h5C: code = 8'h5D;
        8'h3B: code = 8'h4C;  8'h27: code = 8'h52;  8'h2C: code = 8'h41;
        8'h2E: code = 8'h49;  8'h2F: code = 8'h4A;  8'h20: code = 8'h29;
        8'h0D: code = 8'h5A;  8'h08: code = 8'h66;
`ifdef SHIFTED_CHARS_EN
        8'h7E: begin code = 8'h0E; shift = 1'b1; end
        8'h21: begin code = 8'h16; shift = 1'b1; end
        8'h40: begin code = 8'h1E; shift = 1'b1; end
        8'h23: begin code = 8'h26; shift = 1'b1; end
        8'h24: begin code = 8'h25; shift = 1'b1; end
        8'h25: begin code = 8'h2E; shift = 1'b1; end
        8'h5E: begin code = 8'h36; shift = 1'b1; end
        8'h26: begin code = 8'h3D; shift = 1'b1; end
        8'h2A: begin code = 8'h3E; shift = 1'b1; end
        8'h28: begin code = 8'h46; shift = 1'b1; end
        8'h29: begin code = 8'h45; shift = 1'b1; end
        8'h5F: begin code = 8'h4E; shift = 1'b1; end
        8'h2B: begin code = 8'h55; shift = 1'b1; end
        8'h7B: begin code = 8'h54; shift = 1'b1; end
        8'h7D: begin code = 8'h5B; shift = 1'b1; end
        8'h7C: begin code = 8'h5D; shift = 1'b1; end
        8'h3A: begin code = 8'h4C; shift = 1'b1; end
        8'h22: begin code = 8'h52; shift = 1'b1; end
        8'h3C: begin code = 8'h41; shift = 1'b1; end
        8'h3E: begin code = 8'h49; shift = 1'b1; end
        8'h3F: begin code = 8'h4A; shift = 1'b1; end
`endif
        default: hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ascii_to_scan_seq.sv
// ascii_to_scan_seq: turns accepted ASCII characters into full PS/2 Set 2
// keystrokes (make, F0, break), Shift-wrapped when the key needs Shift.
//   i_clk, i_reset      : clock, async active-high reset
//   i_ascii, i_valid    : character in; o_ready high only while IDLE
//   o_scan, o_scan_valid: registered scan byte out; i_scan_ready takes it
//   o_err               : one-cycle pulse for an accepted unmapped character
// Optional feature macro: SHIFTED_CHARS_EN (Shift make/break wrapping).
module ascii_to_scan_seq
  import ps2_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_ascii,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_scan,
  output logic       o_scan_valid,
  input  logic       i_scan_ready,
  output logic       o_err
);

  state_t     state_q, state_n;
  logic [7:0] code_q, code_n;
  logic       err_n;
  logic       take;
  logic [7:0] key_code;
  logic       key_shift;
  logic       key_hit;
  logic       key_ok;
`ifdef SHIFTED_CHARS_EN
  logic       shift_q, shift_n;
`endif

  ascii_to_key u_key (
    .ascii (i_ascii),
    .code  (key_code),
    .shift (key_shift),
    .hit   (key_hit)
  );

`ifdef SHIFTED_CHARS_EN
  assign key_ok = key_hit;
`else
  // Lookup never reports shift in this build; masking keeps the port used.
  assign key_ok = key_hit & ~key_shift;
`endif

  assign o_ready = (state_q == IDLE);
  assign take    = o_scan_valid & i_scan_ready;

  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    err_n   = 1'b0;
`ifdef SHIFTED_CHARS_EN
    shift_n = shift_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (key_ok) begin
            code_n = key_code;
`ifdef SHIFTED_CHARS_EN
            shift_n = key_shift;
            state_n = key_shift ? SH_MK : MK;
`else
            state_n = MK;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
      end
      MK:      if (take) state_n = BRK_PFX;
      BRK_PFX: if (take) state_n = BRK;
      BRK: begin
        if (take) begin
`ifdef SHIFTED_CHARS_EN
          state_n = shift_q ? SH_PFX : IDLE;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef SHIFTED_CHARS_EN
      SH_MK:   if (take) state_n = MK;
      SH_PFX:  if (take) state_n = SH_BRK;
      SH_BRK:  if (take) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // Output byte is registered from the next state, so it appears the cycle
  // after an accept/handshake and stays put while the transmitter stalls.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      code_q       <= '0;
      o_scan       <= '0;
      o_scan_valid <= 1'b0;
      o_err        <= 1'b0;
`ifdef SHIFTED_CHARS_EN
      shift_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      code_q       <= code_n;
      o_scan       <= emit_byte(state_n, code_n);
      o_scan_valid <= (state_n != IDLE);
      o_err        <= err_n;
`ifdef SHIFTED_CHARS_EN
      shift_q      <= shift_n;
`endif
    end
  end

endmodule

// File: tb/tb_ascii_to_scan_seq.sv
// Self-checking bench for ascii_to_scan_seq (directed vectors).
module tb_ascii_to_scan_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ascii = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic [7:0] scan;
  logic       scan_valid;
  logic       scan_ready = 1'b1;
  logic       err;

  int checks   = 0;
  int failures = 0;

  ascii_to_scan_seq dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_ascii      (ascii),
    .i_valid      (valid),
    .o_ready      (ready),
    .o_scan       (scan),
    .o_scan_valid (scan_valid),
    .i_scan_ready (scan_ready),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (scan !== 8'h00) begin failures++; $display("FAIL reset_scan: got %h want 00", scan); end
    checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", scan_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst = 1'b0;
    tick();
    checks++; if (ready !== 1'b1 || scan_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got ready=%b valid=%b want 1/0", ready, scan_valid); end
  endtask

  // Unshifted keys with i_scan_ready high: make, F0, break on consecutive cycles.
  task automatic test_unshifted_keys();
    logic [7:0] chars [10];
    logic [7:0] codes [10];
    logic [7:0] exp [3];
    chars = '{8'h61, 8'h7A, 8'h6D, 8'h30, 8'h39, 8'h20, 8'h3B, 8'h08, 8'h60, 8'h2F};
    codes = '{8'h1C, 8'h1A, 8'h3A, 8'h45, 8'h46, 8'h29, 8'h4C, 8'h66, 8'h0E, 8'h4A};
    scan_ready = 1'b1;
    foreach (chars[i]) begin
      exp = '{codes[i], 8'hF0, codes[i]};
      ascii = chars[i];
      valid = 1'b1;
      tick();
      valid = 1'b0;
      foreach (exp[k]) begin
        checks++;
        if (scan_valid !== 1'b1 || scan !== exp[k] || ready !== 1'b0) begin
          failures++;
          $display("FAIL key_%h_byte%0d: got valid=%b scan=%h ready=%b want 1/%h/0", chars[i], k, scan_valid, scan, ready, exp[k]);
        end
        tick();
      end
      checks++;
      if (scan_valid !== 1'b0 || ready !== 1'b1) begin
        failures++;
        $display("FAIL key_%h_end: got valid=%b ready=%b want 0/1", chars[i], scan_valid, ready);
      end
    end
  endtask

  task automatic test_upper();
    logic [7:0] exp [$];
`ifdef SHIFTED_CHARS_EN
    exp = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
`else
    exp = '{8'h1C, 8'hF0, 8'h1C};
`endif
    ascii = 8'h41;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    foreach (exp[k]) begin
      checks++;
      if (scan_valid !== 1'b1 || scan !== exp[k]) begin
        failures++;
        $display("FAIL upper_A_byte%0d: got valid=%b scan=%h want 1/%h", k, scan_valid, scan, exp[k]);
      end
      tick();
    end
    checks++;
    if (scan_valid !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL upper_A_end: got valid=%b ready=%b want 0/1", scan_valid, ready);
    end
  endtask

  task automatic test_err();
    logic [7:0] bad [$];
    bad = '{8'h7F, 8'hC1};
`ifndef SHIFTED_CHARS_EN
    bad.push_back(8'h21);
    bad.push_back(8'h3F);
`endif
    foreach (bad[i]) begin
      ascii = bad[i];
      valid = 1'b1;
      tick();
      valid = 1'b0;
      checks++;
      if (err !== 1'b1 || scan_valid !== 1'b0 || ready !== 1'b1) begin
        failures++;
        $display("FAIL err_%h_pulse: got err=%b valid=%b ready=%b want 1/0/1", bad[i], err, scan_valid, ready);
      end
      tick();
      checks++;
      if (err !== 1'b0 || scan_valid !== 1'b0 || ready !== 1'b1) begin
        failures++;
        $display("FAIL err_%h_after: got err=%b valid=%b ready=%b want 0/0/1", bad[i], err, scan_valid, ready);
      end
    end
  endtask

  // CR with the transmitter stalling 3 cycles before taking each byte.
  task automatic test_stall();
    logic [7:0] exp [3];
    exp = '{8'h5A, 8'hF0, 8'h5A};
    scan_ready = 1'b0;
    ascii = 8'h0D;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    foreach (exp[k]) begin
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (scan_valid !== 1'b1 || scan !== exp[k]) begin
          failures++;
          $display("FAIL stall_byte%0d_hold%0d: got valid=%b scan=%h want 1/%h", k, c, scan_valid, scan, exp[k]);
        end
        tick();
      end
      scan_ready = 1'b1;
      checks++;
      if (scan_valid !== 1'b1 || scan !== exp[k]) begin
        failures++;
        $display("FAIL stall_byte%0d_take: got valid=%b scan=%h want 1/%h", k, scan_valid, scan, exp[k]);
      end
      tick();
      scan_ready = 1'b0;
    end
    checks++;
    if (scan_valid !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_end: got valid=%b ready=%b want 0/1", scan_valid, ready);
    end
    scan_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [3];
    int pre;
`ifdef SHIFTED_CHARS_EN
    ascii = 8'h3F;
    pre   = 2;
`else
    ascii = 8'h2F;
    pre   = 1;
`endif
    scan_ready = 1'b1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (pre) tick();
    checks++;
    if (scan_valid !== 1'b1 || scan !== 8'hF0) begin
      failures++;
      $display("FAIL midrst_pre: got valid=%b scan=%h want 1/f0", scan_valid, scan);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (scan !== 8'h00 || scan_valid !== 1'b0 || ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: got scan=%h valid=%b ready=%b err=%b want 00/0/1/0", scan, scan_valid, ready, err);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (scan_valid !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_idle: got valid=%b ready=%b want 0/1", scan_valid, ready);
    end
    exp = '{8'h16, 8'hF0, 8'h16};
    ascii = 8'h31;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    foreach (exp[k]) begin
      checks++;
      if (scan_valid !== 1'b1 || scan !== exp[k]) begin
        failures++;
        $display("FAIL midrst_1_byte%0d: got valid=%b scan=%h want 1/%h", k, scan_valid, scan, exp[k]);
      end
      tick();
    end
    checks++;
    if (scan_valid !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_1_end: got valid=%b ready=%b want 0/1", scan_valid, ready);
    end
  endtask

  // "hi" with i_valid held: the next character waits through the busy period.
  task automatic test_back_to_back();
    logic [7:0] exp_h [3];
    logic [7:0] exp_i [3];
    exp_h = '{8'h33, 8'hF0, 8'h33};
    exp_i = '{8'h43, 8'hF0, 8'h43};
    scan_ready = 1'b1;
    ascii = 8'h68;
    valid = 1'b1;
    tick();
    ascii = 8'h69;
    foreach (exp_h[k]) begin
      checks++;
      if (scan_valid !== 1'b1 || scan !== exp_h[k] || ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_h_byte%0d: got valid=%b scan=%h ready=%b want 1/%h/0", k, scan_valid, scan, ready, exp_h[k]);
      end
      tick();
    end
    checks++;
    if (scan_valid !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: got valid=%b ready=%b want 0/1", scan_valid, ready);
    end
    tick();
    valid = 1'b0;
    foreach (exp_i[k]) begin
      checks++;
      if (scan_valid !== 1'b1 || scan !== exp_i[k] || ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_i_byte%0d: got valid=%b scan=%h ready=%b want 1/%h/0", k, scan_valid, scan, ready, exp_i[k]);
      end
      tick();
    end
    checks++;
    if (scan_valid !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: got valid=%b ready=%b want 0/1", scan_valid, ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_unshifted_keys();
    test_upper();
    test_err();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
